// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states, width defaults.
package lsu_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned LEN_W          = 8;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_STORE   = 2'b01,
        OP_COPY    = 2'b10,
        OP_ILLEGAL = 2'b11
    } lsu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdWait,
        StWr,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: single-request LOAD, STORE and byte-wise COPY against a memory
// stage with one-cycle registered read data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] memory_addr,
    output logic              memory_read_enable,
    output logic              memory_write_enable,
    output logic [DATA_W-1:0] memory_write_data,
    input  logic [DATA_W-1:0] memory_read_data
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_next;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              accept;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign accept   = req_valid && req_ready;
    assign cnt_next = cnt_q + 8'd1;
    // COPY walks source and destination together; wrap-around is intentional.
    assign rd_addr  = src_q + ADDR_W'(cnt_q);
    assign wr_addr  = (op_q == OP_COPY) ? (dst_q + ADDR_W'(cnt_q)) : src_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (lsu_op_e'(req_op))
                        OP_LOAD:  state_d = StRd;
                        OP_STORE: state_d = StWr;
                        OP_COPY:  state_d = (req_len == '0) ? StResp : StRd;
                        default:  state_d = StResp;
                    endcase
                end
            end
            StRd:     state_d = StRdWait;
            StRdWait: state_d = (op_q == OP_COPY) ? StWr : StResp;
            StWr: begin
                if (op_q == OP_COPY && cnt_next != len_q) begin
                    state_d = StRd;
                end else begin
                    state_d = StResp;
                end
            end
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Memory strobes and handshake; strobes are gated by rst so no write lands on a reset edge.
    always_comb begin
        req_ready           = (state_q == StIdle) && !rst;
        memory_read_enable  = 1'b0;
        memory_write_enable = 1'b0;
        memory_addr         = '0;
        memory_write_data   = '0;
        if (!rst) begin
            case (state_q)
                StRd: begin
                    memory_read_enable = 1'b1;
                    memory_addr        = rd_addr;
                end
                StWr: begin
                    memory_write_enable = 1'b1;
                    memory_addr         = wr_addr;
                    memory_write_data   = data_q;
                end
                default: ;
            endcase
        end
    end

    // Request latch, copy byte counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_LOAD;
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= lsu_op_e'(req_op);
                src_q  <= req_addr;
                dst_q  <= ADDR_W'(req_data);
                data_q <= req_data;
                len_q  <= req_len;
                cnt_q  <= '0;
            end
            // The byte read for LOAD/COPY becomes the response or the next write data.
            if (state_q == StRdWait) begin
                data_q <= memory_read_data;
            end
            if (state_q == StWr && op_q == OP_COPY) begin
                cnt_q <= cnt_next;
            end

            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            if (state_d == StResp) begin
                resp_valid_q <= 1'b1;
                case (state_q)
                    StIdle:   resp_err_q  <= (lsu_op_e'(req_op) == OP_ILLEGAL);
                    StRdWait: resp_data_q <= memory_read_data;
                    StWr: begin
                        if (op_q == OP_COPY) begin
                            resp_data_q <= DATA_W'(len_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, the request is present.
REQ-006 SHALL have port req_ready, output, 1, the unit can accept a request.
REQ-007 SHALL have port req_op, input, 2, operation code: 00 LOAD, 01 STORE, 10 COPY, 11 illegal.
REQ-008 SHALL have port req_addr, input, ADDR_W, the LOAD/STORE address or the COPY source base.
REQ-009 SHALL have port req_data, input, DATA_W, the STORE data or the COPY destination base.
REQ-010 SHALL have port req_len, input, 8, the COPY byte count; ignored for other ops.
REQ-011 SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port resp_data, output, DATA_W, the LOAD data, the COPY byte count, or 0.
REQ-013 SHALL have port resp_err, output, 1, illegal op flag, qualified by resp_valid.
REQ-014 SHALL have port memory_addr, output, ADDR_W, the address to the memory stage.
REQ-015 SHALL have port memory_read_enable, output, 1, the read strobe.
REQ-016 SHALL have port memory_write_enable, output, 1, the write strobe.
REQ-017 SHALL have port memory_write_data, output, DATA_W, the write data.
REQ-018 SHALL have port memory_read_data, input, DATA_W, registered read data, valid one cycle after the read-enable edge.

Function
REQ-019 SHALL implement the FSM states IDLE, RD, RDWAIT, WR and RESP.
REQ-020 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-021 SHALL latch op, addr, data and len at acceptance; later changes on the req_* inputs have no effect.
REQ-022 LOAD SHALL follow IDLE->RD (read_enable=1, addr=A)->RDWAIT->RESP, where resp_data is sampled from memory_read_data at the RDWAIT edge; resp_valid is high in the 3rd cycle after acceptance.
REQ-023 STORE SHALL follow IDLE->WR (write_enable=1, addr=A, write_data=D)->RESP, with resp_data=0 and resp_valid high in the 2nd cycle after acceptance.
REQ-024 COPY SHALL, for each i=0..len-1, run RD(src+i)->RDWAIT->WR(dst+i), with write data equal to the byte sampled in RDWAIT; this takes 3 cycles per byte and is followed by RESP with resp_data=len.
REQ-025 COPY address arithmetic SHALL be modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00; there is no error on wrap.
REQ-026 COPY with len=0 SHALL go IDLE->RESP with no memory enables and resp_data=0.
REQ-027 The illegal op SHALL go IDLE->RESP with resp_err=1, resp_data=0 and no memory enables.
REQ-028 At most one of memory_read_enable and memory_write_enable SHALL be high in any cycle; both are low in IDLE and RESP.
REQ-029 memory_addr and memory_write_data SHALL be 0 whenever their strobe is low.
REQ-030 resp_valid SHALL be a one-cycle pulse in RESP with no backpressure; RESP always returns to IDLE.
REQ-031 A request with req_valid high in the RESP cycle SHALL NOT be accepted, because req_ready is low there.
REQ-032 The internal byte counter SHALL be 8 bits wide so that len=255 completes 255 bytes.

Reset
REQ-033 While rst=1, state SHALL become IDLE and resp_valid, resp_err, resp_data and the counters SHALL become 0 at the edge.
REQ-034 memory_read_enable and memory_write_enable SHALL be combinationally forced to 0 while rst=1, so that no write lands on the reset edge.
REQ-035 A reset mid-COPY SHALL abandon the copy with no response; bytes already written stay written.
REQ-036 req_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.

Structure
REQ-037 Package lsu_pkg SHALL hold the op encodings (OP_LOAD, OP_STORE, OP_COPY, OP_ILLEGAL), the state enum, and the ADDR_W and DATA_W defaults.
REQ-038 The block SHALL be a single module with no sub-module; the FSM and datapath registers live in one file and connect directly to the memory stage ports.

Verification
REQ-039 STORE addr=0x10 data=0xA5, then LOAD 0x10 -> resp_valid 2 cycles after the STORE acceptance, then resp_data=0xA5 with resp_valid 3 cycles after the LOAD acceptance.
REQ-040 Preload 0xFE=0x11 and 0xFF=0x22, then COPY src=0xFE dst=0x00 len=3 -> mem[0x00..0x02]=0x11, 0x22, mem[0x00] (wrap), resp_data=3, resp_valid 10 cycles after acceptance.
REQ-041 COPY len=0 and op=11 -> no memory strobes, resp_valid next cycle, resp_err=0 and 1 respectively, resp_data=0.
REQ-042 Hold req_valid continuously with back-to-back STOREs -> req_ready low in WR and RESP, one acceptance per 3 cycles, no request lost or duplicated.
REQ-043 Assert rst for 1 cycle during the WR state of byte 2 of a len=4 COPY -> no write on the reset edge, no resp_valid, req_ready=1 after reset, bytes 0-1 written and bytes 2-3 untouched.
REQ-044 Run 1000 random ops under a reference-model scoreboard -> the read and write enables are never high together, and every response matches the model.
